// File: rtl/layer_deserializer_pkg.sv
// Shared types and helpers for the layer stream deserializer.
// Frame state and a counter-width helper that tolerates a zero limit.
package layer_deserializer_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_e;

    // Bits needed to hold 0..n inclusive; never returns 0.
    function automatic int unsigned ctr_width(int unsigned n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/layer_deserializer_gap_timer.sv
// Saturating idle counter: counts enabled cycles up to LIMIT, clear wins.
// expired_o is a registered flag, high while the count sits at LIMIT.
module gap_timer
    import layer_deserializer_pkg::*;
#(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int unsigned TW = ctr_width(LIMIT);
    localparam logic [TW-1:0] LIM = TW'(LIMIT);

    logic [TW-1:0] count_q, count_d;
    logic          expired_q, expired_d;

    // LIMIT == 0 means disabled: the counter never moves and never expires.
    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (enable_i && (LIMIT != 0) && (count_q != LIM))
            count_d = count_q + 1'b1;
        expired_d = (LIMIT != 0) && (count_d == LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/layer_deserializer.sv
// Collects NEURON_NUM serial samples into a double-buffered parallel frame,
// pulsing out_valid on completion and frame_err when a stalled partial frame is dropped.
module layer_deserializer
    import layer_deserializer_pkg::*;
#(
    parameter int unsigned NEURON_NUM = 10,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_valid,
    output logic [NEURON_NUM*DATA_WIDTH-1:0] out_data,
    output logic                             out_valid,
    output logic                             frame_err,
    output logic                             busy
);

    localparam int unsigned CW = ctr_width(NEURON_NUM);
    localparam logic [CW-1:0] LAST = CW'(NEURON_NUM - 1);

    state_e                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [NEURON_NUM*DATA_WIDTH-1:0] out_q, out_d;
    logic                             ov_q, ov_d;
    logic                             fe_q, fe_d;
    logic [DATA_WIDTH-1:0]            asm_q [NEURON_NUM];
    logic                             gap_expired;
    logic                             timeout;

    assign busy    = (state_q == ST_COLLECT);
    assign timeout = busy && !in_valid && gap_expired;

    gap_timer #(
        .LIMIT(TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (busy && !in_valid),
        .clear_i  (in_valid || !busy),
        .expired_o(gap_expired)
    );

    // A sample always wins over a timeout landing in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        ov_d  = 1'b0;
        fe_d  = 1'b0;
        if (in_valid) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                ov_d  = 1'b1;
                for (int k = 0; k < NEURON_NUM; k++)
                    out_d[k*DATA_WIDTH +: DATA_WIDTH] =
                        (k == NEURON_NUM - 1) ? in_data : asm_q[k];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (timeout) begin
            cnt_d = '0;
            fe_d  = 1'b1;
        end
        state_d = (cnt_d != '0) ? ST_COLLECT : ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            fe_q    <= fe_d;
        end
    end

    // Assembly slots are always written before they are read, so no reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NEURON_NUM; k++)
            if (in_valid && (cnt_q == CW'(k)))
                asm_q[k] <= in_data;
    end

    assign out_data  = out_q;
    assign out_valid = ov_q;
    assign frame_err = fe_q;

endmodule

// File: tb/tb_layer_deserializer.sv
// Directed bench for layer_deserializer with NEURON_NUM=4, DATA_WIDTH=16, TIMEOUT=8.
module tb_layer_deserializer;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic [N*DW-1:0] out_data;
    logic            out_valid;
    logic            frame_err;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_deserializer #(
        .NEURON_NUM(N),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .out_data (out_data),
        .out_valid(out_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n, input string tag, input logic exp_busy);
        repeat (n) begin
            tick();
            chk({tag, "_ferr"}, 64'(frame_err), 64'd0);
            chk({tag, "_ov"},   64'(out_valid), 64'd0);
            chk({tag, "_busy"}, 64'(busy),      64'(exp_busy));
        end
    endtask

    task automatic frame_done(input string tag, input logic [63:0] exp);
        chk({tag, "_ov"},   64'(out_valid), 64'd1);
        chk({tag, "_data"}, out_data,       exp);
        chk({tag, "_busy"}, 64'(busy),      64'd0);
        chk({tag, "_ferr"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_data", out_data,        64'd0);
        chk("rst_ov",   64'(out_valid),  64'd0);
        chk("rst_ferr", 64'(frame_err),  64'd0);
        chk("rst_busy", 64'(busy),       64'd0);
        rst_n = 1'b1;
        tick();

        // basic frame; busy high exactly for the three partial cycles
        send(16'h0011); chk("bas_busy1", 64'(busy), 64'd1);
        send(16'h0022); chk("bas_busy2", 64'(busy), 64'd1);
        send(16'h0033); chk("bas_busy3", 64'(busy), 64'd1);
        chk("bas_ov_early", 64'(out_valid), 64'd0);
        send(16'h0044);
        frame_done("bas", 64'h0044_0033_0022_0011);
        idle(1, "bas_after", 1'b0);
        chk("bas_hold", out_data, 64'h0044_0033_0022_0011);

        // sparse frame
        send(16'h00A1); idle(3, "sp1", 1'b1);
        send(16'h00A2); idle(3, "sp2", 1'b1);
        send(16'h00A3); idle(3, "sp3", 1'b1);
        chk("sp_hold", out_data, 64'h0044_0033_0022_0011);
        send(16'h00A4);
        frame_done("sp", 64'h00A4_00A3_00A2_00A1);
        idle(1, "sp_after", 1'b0);

        // back-to-back frames
        for (int i = 1; i <= 8; i++) begin
            send(16'(i));
            if (i == 4)
                frame_done("b2b1", 64'h0004_0003_0002_0001);
            else if (i == 8)
                frame_done("b2b2", 64'h0008_0007_0006_0005);
            else
                chk($sformatf("b2b_ov%0d", i), 64'(out_valid), 64'd0);
        end
        idle(1, "b2b_after", 1'b0);

        // timeout: timer reaches 8 after 8 idle cycles, drop occurs next cycle
        send(16'h0055); send(16'h0066);
        idle(TO, "to_wait", 1'b1);
        tick();
        chk("to_ferr", 64'(frame_err), 64'd1);
        chk("to_busy", 64'(busy),      64'd0);
        chk("to_ov",   64'(out_valid), 64'd0);
        chk("to_data", out_data,       64'h0008_0007_0006_0005);
        idle(1, "to_after", 1'b0);
        send(16'h000A); send(16'h000B); send(16'h000C); send(16'h000D);
        frame_done("to_next", 64'h000D_000C_000B_000A);
        idle(1, "to_next_after", 1'b0);

        // boundary: 7 idle cycles inside a frame is tolerated
        send(16'h0101); send(16'h0102);
        idle(TO - 1, "bnd7", 1'b1);
        send(16'h0103); chk("bnd7_ferr", 64'(frame_err), 64'd0);
        send(16'h0104);
        frame_done("bnd7", 64'h0104_0103_0102_0101);
        idle(1, "bnd7_after", 1'b0);

        // timer at limit but a sample arrives: accepted, no drop
        send(16'h0201); send(16'h0202);
        idle(TO, "bnd8", 1'b1);
        send(16'h0203); chk("bnd8_ferr", 64'(frame_err), 64'd0);
        chk("bnd8_busy", 64'(busy), 64'd1);
        send(16'h0204);
        frame_done("bnd8", 64'h0204_0203_0202_0201);
        idle(1, "bnd8_after", 1'b0);

        // mid-frame reset: outputs clear asynchronously, partial frame lost
        send(16'h0071); send(16'h0072); send(16'h0073);
        rst_n = 1'b0;
        #1;
        chk("mrst_data", out_data,       64'd0);
        chk("mrst_ov",   64'(out_valid), 64'd0);
        chk("mrst_ferr", 64'(frame_err), 64'd0);
        chk("mrst_busy", 64'(busy),      64'd0);
        tick();
        rst_n = 1'b1;
        idle(1, "mrst_rel", 1'b0);
        send(16'h00E1); send(16'h00E2); send(16'h00E3); send(16'h00E4);
        frame_done("mrst", 64'h00E4_00E3_00E2_00E1);
        idle(2, "mrst_after", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
